// File: rtl/open_collector_frame_tx.sv
// Byte-framing transmitter for a shared, pulled-up serial line.
// Sends start, 8 data bits LSB first, odd parity and stop. It waits for an idle
// line before each frame and backs off when another driver pulls the line low
// while this block has it released.
module open_collector_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned IDLE_BITS    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic       LINE_IN,
    output logic       TX_BIT,
    output logic       BUSY,
    output logic       DONE,
    output logic       COLLISION
);

    localparam int unsigned BT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned IC_W        = $clog2(IDLE_CYCLES + 1);

    localparam logic [BT_W-1:0] BT_LAST = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [BT_W-1:0] BT_MID  = BT_W'(CLKS_PER_BIT / 2);
    localparam logic [IC_W-1:0] IC_FULL = IC_W'(IDLE_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]      state_q, state_nxt;
    logic [BT_W-1:0] bit_tmr_q, bit_tmr_nxt;
    logic [2:0]      bit_cnt_q, bit_cnt_nxt;
    logic [IC_W-1:0] idle_cnt_q, idle_cnt_nxt;
    logic [7:0]      data_q, data_nxt;
    logic            parity_q, parity_nxt;
    logic            tx_bit_q, tx_bit_nxt;
    logic            busy_q, busy_nxt;
    logic            done_q, done_nxt;
    logic            coll_q, coll_nxt;
    logic            sync1_q, line_sync;
    logic            bit_end;
    logic            collide;
    logic [2:0]      next_idx;

    assign TX_READY  = (state_q == S_IDLE);
    assign TX_BIT    = tx_bit_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign COLLISION = coll_q;

    // Two-flop synchronizer for the asynchronous line level; idles high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            sync1_q   <= LINE_IN;
            line_sync <= sync1_q;
        end
    end

    // State and registered-output storage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            bit_tmr_q  <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            tx_bit_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            bit_tmr_q  <= bit_tmr_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            idle_cnt_q <= idle_cnt_nxt;
            data_q     <= data_nxt;
            parity_q   <= parity_nxt;
            tx_bit_q   <= tx_bit_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            coll_q     <= coll_nxt;
        end
    end

    // Next-state, bit timing, collision back-off and next output values.
    always_comb begin
        state_nxt    = state_q;
        bit_tmr_nxt  = bit_tmr_q;
        bit_cnt_nxt  = bit_cnt_q;
        idle_cnt_nxt = idle_cnt_q;
        data_nxt     = data_q;
        parity_nxt   = parity_q;
        tx_bit_nxt   = tx_bit_q;
        done_nxt     = 1'b0;
        coll_nxt     = 1'b0;
        next_idx     = bit_cnt_q + 3'd1;
        bit_end      = (bit_tmr_q == BT_LAST);
        // Only meaningful while the line is released: someone else holds it low.
        collide      = tx_bit_q && (bit_tmr_q == BT_MID) && !line_sync;

        case (state_q)
            S_IDLE: begin
                tx_bit_nxt = 1'b1;
                if (TX_VALID) begin
                    data_nxt     = TX_DATA;
                    parity_nxt   = ~^TX_DATA;
                    idle_cnt_nxt = '0;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                tx_bit_nxt  = 1'b1;
                bit_tmr_nxt = '0;
                if (idle_cnt_q == IC_FULL) begin
                    state_nxt    = S_START;
                    tx_bit_nxt   = 1'b0;
                    idle_cnt_nxt = '0;
                end else if (line_sync) begin
                    idle_cnt_nxt = idle_cnt_q + IC_W'(1);
                end else begin
                    idle_cnt_nxt = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt   = S_DATA;
                    bit_tmr_nxt = '0;
                    bit_cnt_nxt = '0;
                    tx_bit_nxt  = data_q[0];
                end else begin
                    bit_tmr_nxt = bit_tmr_q + BT_W'(1);
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (collide) begin
                    state_nxt    = S_WAIT;
                    tx_bit_nxt   = 1'b1;
                    coll_nxt     = 1'b1;
                    idle_cnt_nxt = '0;
                    bit_tmr_nxt  = '0;
                end else if (bit_end) begin
                    bit_tmr_nxt = '0;
                    if (state_q == S_DATA) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_nxt  = S_PARITY;
                            tx_bit_nxt = parity_q;
                        end else begin
                            bit_cnt_nxt = next_idx;
                            tx_bit_nxt  = data_q[next_idx];
                        end
                    end else if (state_q == S_PARITY) begin
                        state_nxt  = S_STOP;
                        tx_bit_nxt = 1'b1;
                    end else begin
                        state_nxt  = S_IDLE;
                        tx_bit_nxt = 1'b1;
                        done_nxt   = 1'b1;
                    end
                end else begin
                    bit_tmr_nxt = bit_tmr_q + BT_W'(1);
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                tx_bit_nxt = 1'b1;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_open_collector_frame_tx.sv
// Testbench for open_collector_frame_tx: per-cycle output history checked
// against a frame model built from the framing rules (start, data LSB first,
// odd parity, stop) and the idle-line / collision timing rules.
module tb_open_collector_frame_tx;

    localparam int C    = 16;
    localparam int N    = 2 * C;
    localparam int F    = 11 * C;
    localparam int HIST = 8192;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       LINE_IN;
    logic       TX_READY;
    logic       TX_BIT;
    logic       BUSY;
    logic       DONE;
    logic       COLLISION;

    open_collector_frame_tx #(.CLKS_PER_BIT(C), .IDLE_BITS(2)) dut (
        .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .LINE_IN(LINE_IN), .TX_BIT(TX_BIT),
        .BUSY(BUSY), .DONE(DONE), .COLLISION(COLLISION)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Output history indexed by edge number, sampled 1 time unit after the edge.
    logic       tx_h   [HIST];
    logic       done_h [HIST];
    logic       coll_h [HIST];
    logic       rdy_h  [HIST];
    logic       busy_h [HIST];
    logic [7:0] dat_h  [HIST];

    task automatic tick();
        logic [7:0] pre;
        pre = TX_DATA;
        @(posedge CLK);
        #1;
        cyc++;
        if (cyc >= HIST) begin
            $display("FAIL history_overflow cyc=%0d limit=%0d", cyc, HIST);
            $fatal(1, "history overflow");
        end
        tx_h[cyc]   = TX_BIT;
        done_h[cyc] = DONE;
        coll_h[cyc] = COLLISION;
        rdy_h[cyc]  = TX_READY;
        busy_h[cyc] = BUSY;
        dat_h[cyc]  = pre;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    // Expected line level for bit slot i of a frame carrying byte d.
    function automatic logic frame_level(input logic [7:0] d, input int i);
        logic [7:0] sh;
        if (i == 0) return 1'b0;
        if (i <= 8) begin
            sh = d >> (i - 1);
            return sh[0];
        end
        if (i == 9) return (($countones(d) % 2) == 0);
        return 1'b1;
    endfunction

    function automatic int count_ones_in(input int which, input int lo, input int hi);
        int n;
        n = 0;
        for (int e = lo; e <= hi; e++) begin
            if (which == 0 && done_h[e] === 1'b1) n++;
            if (which == 1 && coll_h[e] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        int k;
        int lows;
        RST = 1'b1; TX_VALID = 1'b0; LINE_IN = 1'b1; TX_DATA = 8'h00;
        repeat (3) tick();
        n_checks++; if (TX_BIT !== 1'b1) begin n_fail++; $display("FAIL reset_tx_bit got=%b want=1", TX_BIT); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", BUSY); end
        n_checks++; if (DONE !== 1'b0 || COLLISION !== 1'b0) begin n_fail++; $display("FAIL reset_pulses done=%b coll=%b want=0,0", DONE, COLLISION); end
        #2 RST = 1'b0;
        tick();
        n_checks++; if (TX_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", TX_READY); end

        // Reset in the middle of the start bit.
        TX_DATA = 8'h5A; TX_VALID = 1'b1;
        tick();
        k = cyc; TX_VALID = 1'b0;
        run_to(k + N + 1 + 3);
        n_checks++; if (TX_BIT !== 1'b0) begin n_fail++; $display("FAIL midreset_pre_start got=%b want=0", TX_BIT); end
        #3 RST = 1'b1;
        #1;
        n_checks++; if (TX_BIT !== 1'b1) begin n_fail++; $display("FAIL midreset_async_tx got=%b want=1", TX_BIT); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL midreset_async_busy got=%b want=0", BUSY); end
        tick(); tick();
        #2 RST = 1'b0;
        tick();
        n_checks++; if (TX_READY !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL midreset_release ready=%b busy=%b want=1,0", TX_READY, BUSY); end
        k = cyc;
        run_to(k + 250);
        lows = 0;
        for (int e = k; e <= k + 250; e++) if (tx_h[e] !== 1'b1) lows++;
        n_checks++; if (lows != 0) begin n_fail++; $display("FAIL midreset_frame_dropped low_cycles=%0d want=0", lows); end
        n_checks++; if (count_ones_in(0, k, k + 250) != 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d want=0", count_ones_in(0, k, k + 250)); end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d);
        int k;
        int f;
        n_checks++; if (TX_READY !== 1'b1) begin n_fail++; $display("FAIL %s_ready_before got=%b want=1", name, TX_READY); end
        TX_DATA = d; TX_VALID = 1'b1;
        tick();
        k = cyc; TX_VALID = 1'b0; TX_DATA = ~d;
        f = k + N + 1;
        run_to(f + F + 2);
        n_checks++; if (busy_h[k + 1] !== 1'b1 || rdy_h[k + 1] !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after_accept busy=%b ready=%b want=1,0", name, busy_h[k + 1], rdy_h[k + 1]); end
        for (int e = k + 1; e < f; e++) begin
            n_checks++; if (tx_h[e] !== 1'b1) begin n_fail++; $display("FAIL %s_wait_line edge=%0d got=%b want=1", name, e - k, tx_h[e]); end
        end
        for (int t = 0; t < F; t++) begin
            n_checks++; if (tx_h[f + t] !== frame_level(d, t / C)) begin n_fail++; $display("FAIL %s_frame bit=%0d cyc=%0d got=%b want=%b", name, t / C, t % C, tx_h[f + t], frame_level(d, t / C)); end
        end
        n_checks++; if (done_h[f + F] !== 1'b1 || rdy_h[f + F] !== 1'b1 || busy_h[f + F] !== 1'b0) begin n_fail++; $display("FAIL %s_done_at_k+%0d done=%b ready=%b busy=%b want=1,1,0", name, N + F + 1, done_h[f + F], rdy_h[f + F], busy_h[f + F]); end
        n_checks++; if (count_ones_in(0, k, f + F + 2) != 1) begin n_fail++; $display("FAIL %s_done_count got=%0d want=1", name, count_ones_in(0, k, f + F + 2)); end
        n_checks++; if (count_ones_in(1, k, f + F + 2) != 0) begin n_fail++; $display("FAIL %s_no_collision got=%0d want=0", name, count_ones_in(1, k, f + F + 2)); end
    endtask

    task automatic test_busy_line();
        int k;
        int r;
        int f;
        LINE_IN = 1'b0; TX_DATA = 8'h3C; TX_VALID = 1'b1;
        tick();
        k = cyc; TX_VALID = 1'b0;
        run_to(k + 100);
        r = cyc; LINE_IN = 1'b1;
        // two synchronizer edges, N high cycles counted, one edge to start
        f = r + N + 3;
        run_to(f + F + 2);
        for (int e = k + 1; e < f; e++) begin
            n_checks++; if (tx_h[e] !== 1'b1) begin n_fail++; $display("FAIL busy_line_early_start edge=%0d got=%b want=1", e - k, tx_h[e]); end
        end
        for (int t = 0; t < F; t++) begin
            n_checks++; if (tx_h[f + t] !== frame_level(8'h3C, t / C)) begin n_fail++; $display("FAIL busy_line_frame bit=%0d got=%b want=%b", t / C, tx_h[f + t], frame_level(8'h3C, t / C)); end
        end
        n_checks++; if (done_h[f + F] !== 1'b1) begin n_fail++; $display("FAIL busy_line_done got=%b want=1", done_h[f + F]); end
    endtask

    task automatic test_collision();
        int k;
        int f;
        int c;
        int r;
        int f2;
        TX_DATA = 8'hFF; TX_VALID = 1'b1;
        tick();
        k = cyc; TX_VALID = 1'b0;
        f = k + N + 1;
        run_to(f + C + 2);
        LINE_IN = 1'b0;
        c = f + C + C / 2 + 1;
        run_to(c + 4);
        r = cyc; LINE_IN = 1'b1;
        f2 = r + N + 3;
        run_to(f2 + F + 2);
        n_checks++; if (tx_h[f] !== 1'b0) begin n_fail++; $display("FAIL coll_first_start got=%b want=0", tx_h[f]); end
        n_checks++; if (coll_h[c] !== 1'b1 || tx_h[c] !== 1'b1 || busy_h[c] !== 1'b1 || rdy_h[c] !== 1'b0) begin n_fail++; $display("FAIL coll_edge coll=%b tx=%b busy=%b ready=%b want=1,1,1,0", coll_h[c], tx_h[c], busy_h[c], rdy_h[c]); end
        n_checks++; if (count_ones_in(1, k, f2 + F + 2) != 1) begin n_fail++; $display("FAIL coll_pulse_count got=%0d want=1", count_ones_in(1, k, f2 + F + 2)); end
        for (int e = f + C; e < f2; e++) begin
            n_checks++; if (tx_h[e] !== 1'b1) begin n_fail++; $display("FAIL coll_released edge=%0d got=%b want=1", e - f, tx_h[e]); end
        end
        for (int t = 0; t < F; t++) begin
            n_checks++; if (tx_h[f2 + t] !== frame_level(8'hFF, t / C)) begin n_fail++; $display("FAIL coll_retry_frame bit=%0d got=%b want=%b", t / C, tx_h[f2 + t], frame_level(8'hFF, t / C)); end
        end
        n_checks++; if (done_h[f2 + F] !== 1'b1) begin n_fail++; $display("FAIL coll_retry_done got=%b want=1", done_h[f2 + F]); end
        n_checks++; if (count_ones_in(0, k, f2 + F + 2) != 1) begin n_fail++; $display("FAIL coll_done_count got=%0d want=1", count_ones_in(0, k, f2 + F + 2)); end
    endtask

    task automatic test_backpressure();
        int c0;
        int k1;
        int p;
        int last;
        logic want;
        c0 = cyc;
        k1 = c0 + 1;
        p  = N + F + 2;
        last = k1 + 3 * p - 1;
        TX_VALID = 1'b1;
        while (cyc < last) begin
            TX_DATA = 8'($urandom);
            tick();
        end
        TX_VALID = 1'b0;
        run_to(last + 3);
        for (int i = 0; i < 3; i++) begin
            int ki;
            int fi;
            ki = k1 + i * p;
            fi = ki + N + 1;
            for (int t = 0; t < F; t++) begin
                n_checks++; if (tx_h[fi + t] !== frame_level(dat_h[ki], t / C)) begin n_fail++; $display("FAIL bp_frame%0d bit=%0d got=%b want=%b data=%02h", i, t / C, tx_h[fi + t], frame_level(dat_h[ki], t / C), dat_h[ki]); end
            end
            n_checks++; if (done_h[fi + F] !== 1'b1) begin n_fail++; $display("FAIL bp_done%0d got=%b want=1", i, done_h[fi + F]); end
        end
        for (int e = c0; e <= last + 3; e++) begin
            want = (e == c0) || (e == k1 + p - 1) || (e == k1 + 2 * p - 1) || (e >= last);
            n_checks++; if (rdy_h[e] !== want) begin n_fail++; $display("FAIL bp_ready edge=%0d got=%b want=%b", e - c0, rdy_h[e], want); end
        end
        n_checks++; if (count_ones_in(0, c0, last + 3) != 3) begin n_fail++; $display("FAIL bp_done_count got=%0d want=3", count_ones_in(0, c0, last + 3)); end
    endtask

    initial begin
        test_reset();
        test_frame("single_a5", 8'hA5);
        test_frame("parity_00", 8'h00);
        test_frame("parity_01", 8'h01);
        test_busy_line();
        test_collision();
        test_backpressure();
        for (int i = 0; i < 3; i++) test_frame("random", 8'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/open_collector_frame_tx.md
# open_collector_frame_tx

Byte-framing serial transmitter that drives the bidirectional pulled-up serial data line through the open-collector encoder. It sits directly upstream of the encoder: its `TX_BIT` output feeds the encoder's `DIN`, with 1 meaning "release the line" and 0 meaning "pull the line low". Each accepted byte is sent as one frame: start bit, 8 data bits LSB first, odd parity, stop bit. Because the line is shared, the block waits for the line to be idle before sending and detects collisions while it has the line released.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 4.
- `IDLE_BITS`, 2: bit periods the line must be continuously high before a frame starts.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `TX_DATA`  in  8  byte to send; sampled only on the accepting edge.
- `TX_VALID`  in  1  upstream has a byte.
- `TX_READY`  out  1  block can accept a byte; decoded from state == IDLE.
- `LINE_IN`  in  1  raw line level, asynchronous; synchronized internally with 2 flops.
- `TX_BIT`  out  1  registered; connects to the encoder's `DIN`.
- `BUSY`  out  1  registered; high in every state except IDLE.
- `DONE`  out  1  one-cycle pulse after a frame completes.
- `COLLISION`  out  1  one-cycle pulse when a collision aborts a frame.

## Operation
- **States:** IDLE, WAIT_LINE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `TX_READY` = 1 and `TX_BIT` = 1.
  - On `TX_VALID & TX_READY`, latch `TX_DATA` into the shift register, compute the parity bit as `~^TX_DATA`, then go to WAIT_LINE.
- **WAIT_LINE:**
  - An idle counter increments on each cycle the synchronized line is high.
  - Any low cycle clears the counter to 0.
  - When the counter reaches `IDLE_BITS*CLKS_PER_BIT`, go to START.
- **START:** `TX_BIT` = 0 for `CLKS_PER_BIT` cycles.
- **DATA:** 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles. A bit counter runs 0 to 7.
- **PARITY:** the parity bit for `CLKS_PER_BIT` cycles. Parity is odd: the number of ones in data plus parity is odd.
- **STOP:**
  - `TX_BIT` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
  - `DONE` pulses in the first IDLE cycle.
- **Bit timer:**
  - Counts 0 to `CLKS_PER_BIT-1` within each bit; its width is `$clog2(CLKS_PER_BIT)`.
  - It resets to 0 on every state or bit change.
- **Collision detection:**
  - Applies in DATA, PARITY and STOP, only while `TX_BIT` = 1.
  - The synchronized line is sampled when the bit timer = `CLKS_PER_BIT/2`.
  - A low sample means collision: pulse `COLLISION`, force `TX_BIT` = 1, and go to WAIT_LINE with the idle counter cleared.
  - The latched byte and parity are retained and the frame restarts from START. Retries are unlimited.
- **Latched data:** `TX_DATA` changes after the accepting edge have no effect. `TX_VALID` outside IDLE is ignored.
- **Reset (async):**
  - State → IDLE, `TX_BIT` = 1, `BUSY` = 0, `DONE` = 0, `COLLISION` = 0.
  - Synchronizer flops reset to 1; all counters reset to 0.
  - `TX_READY` = 1 once the state is IDLE.
  - Reset mid-frame drops the frame and releases the line immediately, with no glitch low.

## Timing
- With C = `CLKS_PER_BIT` and N = `IDLE_BITS*C`:
  - Accepting edge at cycle k; WAIT_LINE occupies cycles k+1 through k+N on an idle line.
  - `TX_BIT` falls to 0 at edge k+N+1.
  - The frame occupies 11*C cycles.
  - `DONE` is high in cycle k+N+11C+1, alongside `TX_READY` = 1.
- Defaults: `TX_BIT` low at k+33; `DONE` at k+209.
- The minimum gap between frames is N cycles of line idle, from WAIT_LINE.
- Line-level sampling has 2 cycles of synchronizer latency. Mid-bit sampling tolerates this for C ≥ 4.
- `COLLISION` and the move to WAIT_LINE occur on the edge after the low mid-bit sample. `TX_BIT` is 1 on that same edge.
- `BUSY` rises on the edge after acceptance and falls on the edge where `DONE` rises.

## Test plan
- **Reset:** assert `RST` mid-frame while `TX_BIT` = 0 → `TX_BIT` = 1 and `BUSY` = 0 asynchronously, before the next clock edge; `TX_READY` = 1 after release.
- **Single byte, idle line:** send 0xA5 with defaults → `TX_BIT` sequence is 0,1,0,1,0,0,1,0,1,1,1, each bit 16 cycles; parity = 1 (four ones); `DONE` at k+209.
- **Parity:** send 0x00 → parity bit 1; send 0x01 → parity bit 0.
- **Busy line:** hold `LINE_IN` = 0 for 100 cycles after acceptance → no start bit until 32 consecutive high cycles have followed the release.
- **Collision:** send 0xFF and force `LINE_IN` low mid-bit during data bit 0 → one `COLLISION` pulse, line released, a full retry of 0xFF after 32 idle cycles, then one `DONE`.
- **Backpressure:** hold `TX_VALID` high with a changing `TX_DATA` → exactly one byte accepted per frame, `TX_READY` only in IDLE, each frame carries the value present on its accepting edge.
